// File: rtl/sysid_regfile_if.sv
// Avalon-MM slave bus bundle for the system-identification register file.
// The host drives word-addressed single-cycle strobes; the slave returns registered read data.
interface sysid_regfile_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [31:0]           writedata;
    logic [3:0]            byteenable;
    logic [31:0]           readdata;
    logic                  readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_regfile.sv
// System-ID / housekeeping register file: ID and build stamp, 64-bit uptime with
// coherent high-word snapshot, scratch, control/status and read-only user status words.
module sysid_regfile #(
    parameter logic [31:0] ID_VALUE       = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP      = 32'h0000_0000,
    parameter logic [31:0] SCRATCH_RESET  = 32'h0000_0000,
    parameter int          NUM_USER_WORDS = 2,
    parameter int          ADDR_WIDTH     = 4,
    localparam int         US_W           = (NUM_USER_WORDS == 0) ? 32 : 32 * NUM_USER_WORDS
) (
    input  logic                   clock,
    input  logic                   reset,
    sysid_regfile_if.slave         bus,
    input  logic [US_W-1:0]        user_status
);

    localparam logic [ADDR_WIDTH-1:0] A_ID      = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_STAMP   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_UP_LO   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_UP_HI   = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_SCRATCH = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL    = ADDR_WIDTH'(5);

    logic [63:0] counter;
    logic [31:0] snapshot;
    logic [31:0] scratch;
    logic        freeze;
    logic        wrap;

    logic [31:0] rd_mux;
    logic        wr_scratch;
    logic        wr_ctrl;
    logic        wr_lo;
    logic        wr_hi;
    logic        rd_lo;
    logic        clr;
    logic        wrap_clr;
    logic        cnt_wrap;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    always_comb begin
        wr_scratch = bus.write && (bus.address == A_SCRATCH);
        wr_ctrl    = bus.write && (bus.address == A_CTRL);
        wr_lo      = bus.write && (bus.address == A_UP_LO);
        wr_hi      = bus.write && (bus.address == A_UP_HI);
        rd_lo      = bus.read  && (bus.address == A_UP_LO);
        clr        = wr_ctrl && bus.byteenable[0] && bus.writedata[0];
        wrap_clr   = wr_ctrl && bus.byteenable[1] && bus.writedata[8];
        // A clear edge does not count, so it can never produce a wrap.
        cnt_wrap   = !freeze && !clr && (&counter);
    end

    // Read mux always sees pre-write state, so a same-cycle write is not visible yet.
    always_comb begin
        rd_mux = 32'h0;
        case (bus.address)
            A_ID:      rd_mux = ID_VALUE;
            A_STAMP:   rd_mux = TIMESTAMP;
            A_UP_LO:   rd_mux = counter[31:0];
            A_UP_HI:   rd_mux = snapshot;
            A_SCRATCH: rd_mux = scratch;
            A_CTRL:    rd_mux = {23'h0, wrap, 6'h0, freeze, 1'b0};
            default: begin
                for (int k = 0; k < NUM_USER_WORDS; k++) begin
                    if (bus.address == ADDR_WIDTH'(6 + k)) begin
                        rd_mux = user_status[32*k +: 32];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.readdata      <= 32'h0;
            bus.readdatavalid <= 1'b0;
            counter           <= 64'h0;
            snapshot          <= 32'h0;
            scratch           <= SCRATCH_RESET;
            freeze            <= 1'b0;
            wrap              <= 1'b0;
        end else begin
            bus.readdatavalid <= bus.read;
            if (bus.read) begin
                bus.readdata <= rd_mux;
            end

            if (wr_scratch) begin
                scratch <= be_merge(scratch, bus.writedata, bus.byteenable);
            end

            if (wr_ctrl && bus.byteenable[0]) begin
                freeze <= bus.writedata[1];
            end

            if (cnt_wrap) begin
                wrap <= 1'b1;
            end else if (wrap_clr) begin
                wrap <= 1'b0;
            end

            if (clr) begin
                counter  <= 64'h0;
                snapshot <= 32'h0;
            end else begin
                if (freeze) begin
                    if (wr_lo) begin
                        counter[31:0] <= be_merge(counter[31:0], bus.writedata, bus.byteenable);
                    end
                    if (wr_hi) begin
                        counter[63:32] <= be_merge(counter[63:32], bus.writedata, bus.byteenable);
                    end
                end else begin
                    counter <= counter + 64'h1;
                end
                if (rd_lo) begin
                    snapshot <= counter[63:32];
                end
            end
        end
    end

endmodule

// File: tb/tb_sysid_regfile.sv
// Directed self-checking bench for sysid_regfile.
module tb_sysid_regfile;

    localparam logic [31:0] ID_V    = 32'hC0DE_1234;
    localparam logic [31:0] STAMP_V = 32'h2024_0601;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] user_status;
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] d;

    sysid_regfile_if #(.ADDR_WIDTH(4)) bus ();

    sysid_regfile #(
        .ID_VALUE(ID_V),
        .TIMESTAMP(STAMP_V),
        .SCRATCH_RESET(32'h0000_0000),
        .NUM_USER_WORDS(2),
        .ADDR_WIDTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .user_status(user_status)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus.address    = addr;
        bus.writedata  = data;
        bus.byteenable = be;
        bus.write      = 1'b1;
        step();
        bus.write      = 1'b0;
        bus.byteenable = 4'h0;
    endtask

    task automatic rd(input logic [3:0] addr, output logic [31:0] data);
        bus.address = addr;
        bus.read    = 1'b1;
        step();
        bus.read    = 1'b0;
        chk("rdvalid", {31'h0, bus.readdatavalid}, 32'h1);
        data = bus.readdata;
    endtask

    initial begin
        reset          = 1'b1;
        bus.address    = '0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = 32'h0;
        bus.byteenable = 4'h0;
        user_status    = {32'h1234_5678, 32'hCAFE_0001};
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", {31'h0, bus.readdatavalid}, 32'h0);
        chk("rst_data", bus.readdata, 32'h0);
        reset = 1'b0;

        // back-to-back reads of ID then TIMESTAMP
        bus.read = 1'b1; bus.address = 4'd0;
        step();
        chk("b2b_valid0", {31'h0, bus.readdatavalid}, 32'h1);
        chk("id", bus.readdata, ID_V);
        bus.address = 4'd1;
        step();
        chk("b2b_valid1", {31'h0, bus.readdatavalid}, 32'h1);
        chk("timestamp", bus.readdata, STAMP_V);
        bus.read = 1'b0;
        step();
        chk("idle_valid", {31'h0, bus.readdatavalid}, 32'h0);
        chk("hold_data", bus.readdata, STAMP_V);
        rd(4'd15, d); chk("unmapped15", d, 32'h0);

        // scratch with byte enables, then same-cycle read/write
        rd(4'd4, d); chk("scratch_rst", d, 32'h0);
        wr(4'd4, 32'hA5A5_A5A5, 4'b0101);
        rd(4'd4, d); chk("scratch_be", d, 32'h00A5_00A5);
        bus.writedata = 32'h1357_9BDF; bus.byteenable = 4'hF; bus.write = 1'b1;
        rd(4'd4, d); chk("rw_old", d, 32'h00A5_00A5);
        bus.write = 1'b0;
        rd(4'd4, d); chk("rw_new", d, 32'h1357_9BDF);

        // wrap test
        wr(4'd5, 32'h0000_0002, 4'b0001);
        rd(4'd5, d); chk("ctrl_freeze", d, 32'h0000_0002);
        wr(4'd2, 32'hFFFF_FFFE, 4'hF);
        wr(4'd3, 32'hFFFF_FFFF, 4'hF);
        wr(4'd5, 32'h0000_0000, 4'b0001);
        repeat (4) step();
        rd(4'd2, d); chk("wrap_lo", d, 32'h0000_0002);
        rd(4'd3, d); chk("wrap_hi", d, 32'h0000_0000);
        rd(4'd5, d); chk("wrap_set", d, 32'h0000_0100);
        wr(4'd5, 32'h0000_0100, 4'b0001);
        rd(4'd5, d); chk("wrap_clr_noln1", d, 32'h0000_0100);
        wr(4'd5, 32'h0000_0100, 4'b0010);
        rd(4'd5, d); chk("wrap_clr", d, 32'h0000_0000);
        wr(4'd3, 32'h0000_5555, 4'hF);
        rd(4'd2, d);
        rd(4'd3, d); chk("preload_unfrozen", d, 32'h0000_0000);

        // frozen preload, snapshot, byte-enabled preload, clear
        wr(4'd5, 32'h0000_0002, 4'b0001);
        wr(4'd2, 32'hFFFF_FFF0, 4'hF);
        wr(4'd3, 32'h0000_0001, 4'hF);
        rd(4'd2, d); chk("frz_lo", d, 32'hFFFF_FFF0);
        rd(4'd3, d); chk("frz_hi", d, 32'h0000_0001);
        wr(4'd2, 32'hAABB_CCDD, 4'b0011);
        rd(4'd2, d); chk("preload_be", d, 32'hFFFF_CCDD);
        wr(4'd5, 32'h0000_0003, 4'b0001);
        rd(4'd3, d); chk("clr_snap", d, 32'h0000_0000);
        rd(4'd2, d); chk("clr_lo", d, 32'h0000_0000);
        rd(4'd3, d); chk("clr_hi", d, 32'h0000_0000);
        rd(4'd5, d); chk("clr_selfclr", d, 32'h0000_0002);

        // user status and read-only words
        rd(4'd6, d); chk("user0", d, 32'hCAFE_0001);
        rd(4'd7, d); chk("user1", d, 32'h1234_5678);
        wr(4'd7, 32'hFFFF_FFFF, 4'hF);
        rd(4'd7, d); chk("user1_ro", d, 32'h1234_5678);
        rd(4'd8, d); chk("past_user", d, 32'h0000_0000);
        wr(4'd0, 32'h1111_1111, 4'hF);
        rd(4'd0, d); chk("id_ro", d, ID_V);

        // reset coincident with a read cancels it
        bus.address = 4'd4; bus.read = 1'b1; reset = 1'b1;
        step();
        bus.read = 1'b0;
        chk("rst_cancel", {31'h0, bus.readdatavalid}, 32'h0);
        step();
        chk("rst_cancel2", {31'h0, bus.readdatavalid}, 32'h0);
        reset = 1'b0;
        rd(4'd2, d); chk("restart0", d, 32'h0000_0000);
        rd(4'd2, d); chk("restart1", d, 32'h0000_0001);
        rd(4'd4, d); chk("scratch_rst2", d, 32'h0000_0000);
        rd(4'd5, d); chk("ctrl_rst", d, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
